// File: rtl/inst_encoder.sv
// Instruction encoder: turns field-level requests into 32-bit MIPS-style words and
// streams them, with their instruction-memory byte addresses, through a
// valid/ready write port. Sessions are framed by start/stop pulses.
// Build option: define INST_ENC_SHIFT_EN to enable sll/srl/sra (op_sel 5-7);
// without it those selectors are rejected like any other invalid op.
module inst_encoder (
   input  logic        clock,
   input  logic        resetn,
   input  logic        start,
   input  logic        stop,
   input  logic [31:0] addr_in,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [4:0]  op_sel,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [4:0]  sa,
   input  logic [15:0] imm,
   input  logic [25:0] target,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_data,
   output logic [15:0] count,
   output logic        err,
   output logic        done
);

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

   state_e      state_q, state_d;
   logic        out_valid_q, out_valid_d;
   logic [31:0] data_q, data_d;
   logic [31:0] addr_q, addr_d;
   logic [15:0] count_q, count_d;
   logic        err_q, err_d;

   logic [31:0] enc_word;
   logic        enc_ok;
   logic        accept;
   logic        fire;

`ifndef INST_ENC_SHIFT_EN
   // sa only feeds the shift encodings
   logic unused_sa;
   assign unused_sa = ^sa;
`endif

   // Combinational encode of the current request fields
   always_comb begin
      enc_word = 32'h0;
      enc_ok   = 1'b1;
      unique case (op_sel)
         5'd0:  enc_word = {6'b000000, rs, rt, rd, 5'd0, 6'b100000};
         5'd1:  enc_word = {6'b000000, rs, rt, rd, 5'd0, 6'b100010};
         5'd2:  enc_word = {6'b000000, rs, rt, rd, 5'd0, 6'b100100};
         5'd3:  enc_word = {6'b000000, rs, rt, rd, 5'd0, 6'b100101};
         5'd4:  enc_word = {6'b000000, rs, rt, rd, 5'd0, 6'b100110};
`ifdef INST_ENC_SHIFT_EN
         5'd5:  enc_word = {6'b000000, 5'd0, rt, rd, sa, 6'b000000};
         5'd6:  enc_word = {6'b000000, 5'd0, rt, rd, sa, 6'b000010};
         5'd7:  enc_word = {6'b000000, 5'd0, rt, rd, sa, 6'b000011};
`endif
         5'd8:  enc_word = {6'b001000, rs, rt, imm};
         5'd9:  enc_word = {6'b001100, rs, rt, imm};
         5'd10: enc_word = {6'b001101, rs, rt, imm};
         5'd11: enc_word = {6'b001110, rs, rt, imm};
         5'd12: enc_word = {6'b100011, rs, rt, imm};
         5'd13: enc_word = {6'b101011, rs, rt, imm};
         5'd14: enc_word = {6'b000100, rs, rt, imm};
         5'd15: enc_word = {6'b000101, rs, rt, imm};
         5'd16: enc_word = {6'b001111, 5'd0, rt, imm};
         5'd17: enc_word = {6'b000011, target};
         default: enc_ok = 1'b0;
      endcase
   end

   assign fire   = out_valid_q & out_ready;
   assign accept = in_valid & in_ready;

   // State register
   always_ff @(posedge clock) begin
      if (!resetn) state_q <= StIdle;
      else         state_q <= state_d;
   end

   // Next-state: start wins over stop and restarts from any state
   always_comb begin
      state_d = state_q;
      if (start) begin
         state_d = StRun;
      end else begin
         unique case (state_q)
            StRun:   if (stop) state_d = StDrain;
            StDrain: if (!out_valid_q) state_d = StDone;
            default: state_d = state_q;
         endcase
      end
   end

   // FSM-derived outputs
   always_comb begin
      in_ready = (state_q == StRun) & (~out_valid_q | out_ready);
      done     = (state_q == StDone);
   end

   // Datapath next-state: retire on handshake, then load any newly accepted word
   always_comb begin
      out_valid_d = out_valid_q;
      data_d      = data_q;
      addr_d      = addr_q;
      count_d     = count_q;
      err_d       = err_q;
      if (start) begin
         out_valid_d = 1'b0;
         addr_d      = addr_in;
         count_d     = 16'h0;
         err_d       = 1'b0;
      end else begin
         if (fire) begin
            out_valid_d = 1'b0;
            addr_d      = addr_q + 32'd4;
            if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
         end
         if (accept) begin
            if (enc_ok) begin
               out_valid_d = 1'b1;
               data_d      = enc_word;
            end else begin
               err_d = 1'b1;
            end
         end
      end
   end

   // Datapath registers; reset drops any pending word
   always_ff @(posedge clock) begin
      if (!resetn) begin
         out_valid_q <= 1'b0;
         data_q      <= 32'h0;
         addr_q      <= 32'h0;
         count_q     <= 16'h0;
         err_q       <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         data_q      <= data_d;
         addr_q      <= addr_d;
         count_q     <= count_d;
         err_q       <= err_d;
      end
   end

   assign out_valid = out_valid_q;
   assign imem_data = data_q;
   assign imem_addr = addr_q;
   assign count     = count_q;
   assign err       = err_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed self-checking bench for inst_encoder. Inputs change 1 time unit after
// the rising edge; outputs are sampled at that same point.
module tb_inst_encoder;

   logic        clock = 1'b0;
   logic        resetn;
   logic        start;
   logic        stop;
   logic [31:0] addr_in;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  op_sel;
   logic [4:0]  rs, rt, rd, sa;
   logic [15:0] imm;
   logic [25:0] target;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic [15:0] count;
   logic        err;
   logic        done;

   int total = 0;
   int bad   = 0;

   inst_encoder dut (
      .clock     (clock),
      .resetn    (resetn),
      .start     (start),
      .stop      (stop),
      .addr_in   (addr_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_sel    (op_sel),
      .rs        (rs),
      .rt        (rt),
      .rd        (rd),
      .sa        (sa),
      .imm       (imm),
      .target    (target),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .imem_addr (imem_addr),
      .imem_data (imem_data),
      .count     (count),
      .err       (err),
      .done      (done)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic begin_session(input logic [31:0] a);
      addr_in = a;
      start   = 1'b1;
      tick();
      start   = 1'b0;
   endtask

   // Present one request for a single cycle; caller ensures in_ready is high
   task automatic send(input logic [4:0] op, input logic [4:0] s, input logic [4:0] t,
                       input logic [4:0] d, input logic [4:0] sh, input logic [15:0] im,
                       input logic [25:0] tg);
      op_sel = op; rs = s; rt = t; rd = d; sa = sh; imm = im; target = tg;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      tick();
      tick();
      total += 7;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
      if (in_ready !== 1'b0)  begin bad++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
      if (imem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", imem_addr); end
      if (imem_data !== 32'h0) begin bad++; $display("FAIL rst_data got=%h exp=0", imem_data); end
      if (count !== 16'h0) begin bad++; $display("FAIL rst_count got=%h exp=0", count); end
      if (err !== 1'b0)  begin bad++; $display("FAIL rst_err got=%b exp=0", err); end
      if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
      resetn = 1'b1;
      tick();
   endtask

   task automatic test_add();
      out_ready = 1'b1;
      begin_session(32'h100);
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL add_in_ready got=%b exp=1", in_ready); end
      send(5'd0, 5'd1, 5'd2, 5'd3, 5'd7, 16'h0, 26'h0);  // sa must be ignored for add
      total += 3;
      if (out_valid !== 1'b1) begin bad++; $display("FAIL add_valid got=%b exp=1", out_valid); end
      if (imem_data !== 32'h00221820) begin bad++; $display("FAIL add_data got=%h exp=00221820", imem_data); end
      if (imem_addr !== 32'h100) begin bad++; $display("FAIL add_addr got=%h exp=00000100", imem_addr); end
      tick();
      total += 3;
      if (count !== 16'd1) begin bad++; $display("FAIL add_count got=%0d exp=1", count); end
      if (out_valid !== 1'b0) begin bad++; $display("FAIL add_retire got=%b exp=0", out_valid); end
      if (imem_addr !== 32'h104) begin bad++; $display("FAIL add_next_addr got=%h exp=00000104", imem_addr); end
   endtask

   task automatic test_lw_jal();
      out_ready = 1'b1;
      begin_session(32'h200);
      send(5'd12, 5'd29, 5'd8, 5'd0, 5'd0, 16'hFFFC, 26'h0);
      total += 2;
      if (imem_data !== 32'h8FA8FFFC) begin bad++; $display("FAIL lw_data got=%h exp=8FA8FFFC", imem_data); end
      if (imem_addr !== 32'h200) begin bad++; $display("FAIL lw_addr got=%h exp=00000200", imem_addr); end
      send(5'd17, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000040);
      total += 3;
      if (out_valid !== 1'b1) begin bad++; $display("FAIL jal_valid got=%b exp=1", out_valid); end
      if (imem_data !== 32'h0C000040) begin bad++; $display("FAIL jal_data got=%h exp=0C000040", imem_data); end
      if (imem_addr !== 32'h204) begin bad++; $display("FAIL jal_addr got=%h exp=00000204", imem_addr); end
      tick();
      total++;
      if (count !== 16'd2) begin bad++; $display("FAIL lwjal_count got=%0d exp=2", count); end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      begin_session(32'h300);
      send(5'd16, 5'd9, 5'd4, 5'd0, 5'd0, 16'h1234, 26'h0);  // lui: rs dropped
      for (int i = 0; i < 3; i++) begin
         total += 4;
         if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", i, in_ready); end
         if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d] got=%b exp=1", i, out_valid); end
         if (imem_data !== 32'h3C041234) begin bad++; $display("FAIL bp_data[%0d] got=%h exp=3C041234", i, imem_data); end
         if (imem_addr !== 32'h300) begin bad++; $display("FAIL bp_addr[%0d] got=%h exp=00000300", i, imem_addr); end
         tick();
      end
      out_ready = 1'b1;
      tick();
      tick();
      total += 3;
      if (count !== 16'd1) begin bad++; $display("FAIL bp_count got=%0d exp=1", count); end
      if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_retire got=%b exp=0", out_valid); end
      if (imem_addr !== 32'h304) begin bad++; $display("FAIL bp_next_addr got=%h exp=00000304", imem_addr); end
   endtask

   task automatic test_invalid();
      out_ready = 1'b1;
      begin_session(32'h400);
      send(5'd20, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
      total += 4;
      if (err !== 1'b1) begin bad++; $display("FAIL inv_err got=%b exp=1", err); end
      if (out_valid !== 1'b0) begin bad++; $display("FAIL inv_valid got=%b exp=0", out_valid); end
      if (count !== 16'd0) begin bad++; $display("FAIL inv_count got=%0d exp=0", count); end
      if (imem_addr !== 32'h400) begin bad++; $display("FAIL inv_addr got=%h exp=00000400", imem_addr); end
      begin_session(32'h480);
      total++;
      if (err !== 1'b0) begin bad++; $display("FAIL start_clears_err got=%b exp=0", err); end
      send(5'd7, 5'd0, 5'd4, 5'd5, 5'd2, 16'h0, 26'h0);
`ifdef INST_ENC_SHIFT_EN
      total += 3;
      if (err !== 1'b0) begin bad++; $display("FAIL sra_err got=%b exp=0", err); end
      if (out_valid !== 1'b1) begin bad++; $display("FAIL sra_valid got=%b exp=1", out_valid); end
      if (imem_data !== 32'h00042883) begin bad++; $display("FAIL sra_data got=%h exp=00042883", imem_data); end
`else
      total += 3;
      if (err !== 1'b1) begin bad++; $display("FAIL sra_err got=%b exp=1", err); end
      if (out_valid !== 1'b0) begin bad++; $display("FAIL sra_valid got=%b exp=0", out_valid); end
      if (count !== 16'd0) begin bad++; $display("FAIL sra_count got=%0d exp=0", count); end
`endif
      tick();
   endtask

   task automatic test_wrap_drain();
      int waited;
      out_ready = 1'b1;
      begin_session(32'hFFFFFFFC);
      send(5'd8, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0005, 26'h0);
      send(5'd1, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0, 26'h0);
      total += 2;
      if (imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_addr got=%h exp=00000000", imem_addr); end
      if (imem_data !== 32'h00853022) begin bad++; $display("FAIL wrap_data got=%h exp=00853022", imem_data); end
      out_ready = 1'b0;
      stop      = 1'b1;
      tick();
      stop      = 1'b0;
      total += 3;
      if (done !== 1'b0) begin bad++; $display("FAIL drain_done got=%b exp=0", done); end
      if (out_valid !== 1'b1) begin bad++; $display("FAIL drain_valid got=%b exp=1", out_valid); end
      if (in_ready !== 1'b0) begin bad++; $display("FAIL drain_in_ready got=%b exp=0", in_ready); end
      out_ready = 1'b1;
      tick();
      waited = 0;
      while (done !== 1'b1 && waited < 8) begin
         tick();
         waited++;
      end
      total += 3;
      if (done !== 1'b1) begin bad++; $display("FAIL drain_to_done got=%b exp=1", done); end
      if (count !== 16'd2) begin bad++; $display("FAIL drain_count got=%0d exp=2", count); end
      if (imem_addr !== 32'h4) begin bad++; $display("FAIL drain_addr got=%h exp=00000004", imem_addr); end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      total++;
      if (done !== 1'b1) begin bad++; $display("FAIL stop_in_done got=%b exp=1", done); end
   endtask

   task automatic test_restart();
      out_ready = 1'b0;
      begin_session(32'h500);
      send(5'd2, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0, 26'h0);
      addr_in = 32'h600;
      start   = 1'b1;
      stop    = 1'b1;  // start must win
      tick();
      start   = 1'b0;
      stop    = 1'b0;
      total += 4;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL rs_valid got=%b exp=0", out_valid); end
      if (imem_addr !== 32'h600) begin bad++; $display("FAIL rs_addr got=%h exp=00000600", imem_addr); end
      if (in_ready !== 1'b1) begin bad++; $display("FAIL rs_in_ready got=%b exp=1", in_ready); end
      if (done !== 1'b0) begin bad++; $display("FAIL rs_done got=%b exp=0", done); end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      begin_session(32'h700);
      send(5'd3, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
      total++;
      if (out_valid !== 1'b1) begin bad++; $display("FAIL rm_pending got=%b exp=1", out_valid); end
      resetn    = 1'b0;
      out_ready = 1'b1;
      tick();
      total += 6;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL rm_valid got=%b exp=0", out_valid); end
      if (in_ready !== 1'b0) begin bad++; $display("FAIL rm_in_ready got=%b exp=0", in_ready); end
      if (imem_addr !== 32'h0) begin bad++; $display("FAIL rm_addr got=%h exp=0", imem_addr); end
      if (imem_data !== 32'h0) begin bad++; $display("FAIL rm_data got=%h exp=0", imem_data); end
      if (count !== 16'h0) begin bad++; $display("FAIL rm_count got=%0d exp=0", count); end
      if (err !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL rm_flags got=%b%b exp=00", err, done); end
      resetn = 1'b1;
      tick();
      total++;
      if (count !== 16'h0) begin bad++; $display("FAIL rm_no_write got=%0d exp=0", count); end
   endtask

   initial begin
      resetn = 1'b0; start = 1'b0; stop = 1'b0; addr_in = 32'h0;
      in_valid = 1'b0; out_ready = 1'b0;
      op_sel = 5'd0; rs = 5'd0; rt = 5'd0; rd = 5'd0; sa = 5'd0; imm = 16'h0; target = 26'h0;
      #1;
      test_reset();
      test_add();
      test_lw_jal();
      test_backpressure();
      test_invalid();
      test_wrap_drain();
      test_restart();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
